// File: rtl/wb_slave_mem.sv
// Wishbone classic single-transfer slave backed by a small register array.
// Each accepted cycle is latched, optionally delayed by WAIT_STATES cycles,
// then committed and acknowledged with a single-cycle registered ack pulse.
module wb_slave_mem #(
    parameter int BASE_ADDRESS = 0,
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_COUNT   = 16,
    parameter int AU_IN_DATA   = 1,
    parameter int WAIT_STATES  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o
);

    localparam int                    IDX_W    = (DATA_COUNT > 1) ? $clog2(DATA_COUNT) : 1;
    localparam int                    AU_SHIFT = $clog2(AU_IN_DATA);
    localparam logic [ADDR_WIDTH-1:0] BASE_L   = ADDR_WIDTH'(BASE_ADDRESS);
    localparam logic [ADDR_WIDTH:0]   COUNT_L  = (ADDR_WIDTH + 1)'(DATA_COUNT);
    localparam logic [3:0]            WAIT_L   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
    logic                    ack_q, ack_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [DATA_WIDTH-1:0]   mem_q [DATA_COUNT];

    logic                    req;
    logic                    commit;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   off;
    logic [ADDR_WIDTH-1:0]   idx_full;
    logic [IDX_W-1:0]        idx;
    logic                    hit;

    // Decode works on the latched address so late bus changes cannot leak in.
    assign req      = cyc_i & stb_i;
    assign off      = adr_q - BASE_L;
    assign idx_full = off >> AU_SHIFT;
    assign hit      = (adr_q >= BASE_L) && ({1'b0, idx_full} < COUNT_L);
    assign idx      = idx_full[IDX_W-1:0];
    assign commit   = (state_q == S_ACK) && req;

    assign ack_o = ack_q;
    assign dat_o = dat_q;

    // State, wait counter, latched request and registered outputs.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

    // Next-state logic: accept, count wait states, abort on cyc/stb drop.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        we_d    = we_q;
        wdat_d  = wdat_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    adr_d  = adr_i;
                    we_d   = we_i;
                    wdat_d = dat_i;
                    if (WAIT_STATES == 0) begin
                        state_d = S_ACK;
                    end else begin
                        cnt_d   = WAIT_L;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = S_ACK;
                end
            end
            S_ACK:   state_d = req ? S_RESP : S_IDLE;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: ack and read data only on a committed access.
    always_comb begin
        ack_d  = 1'b0;
        dat_d  = dat_q;
        mem_we = 1'b0;
        if (commit) begin
            ack_d = 1'b1;
            if (we_q) mem_we = hit;
            else      dat_d  = hit ? mem_q[idx] : '0;
        end
    end

    // Register array; misses never write.
    // NOTE: the array is reset deliberately, because reads after reset must return zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DATA_COUNT; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[idx] <= wdat_q;
        end
    end

endmodule

// File: tb/tb_wb_slave_mem.sv
// Self-checking bench for wb_slave_mem: directed cases plus randomized traffic
// compared against an address-arithmetic model of the array.
module tb_wb_slave_mem;

    localparam int BASE = 64;
    localparam int DW   = 16;
    localparam int AW   = 16;
    localparam int DC   = 12;
    localparam int AU   = 2;
    localparam int WS   = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cyc_i = 1'b0;
    logic          stb_i = 1'b0;
    logic          we_i = 1'b0;
    logic [AW-1:0] adr_i = '0;
    logic [DW-1:0] dat_i = '0;
    logic [DW-1:0] dat_o;
    logic          ack_o;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] model_mem [DC];
    logic [DW-1:0] last_rd;

    wb_slave_mem #(
        .BASE_ADDRESS(BASE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .DATA_COUNT(DC), .AU_IN_DATA(AU), .WAIT_STATES(WS)
    ) dut (
        .clk(clk), .rst(rst), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_hit(input int adr);
        return (adr >= BASE) && ((adr - BASE) / AU < DC);
    endfunction

    function automatic int m_idx(input int adr);
        return (adr - BASE) / AU;
    endfunction

    // Full transfer: check latency, read data, and one-cycle ack width.
    task automatic do_xfer(input bit we, input int adr, input logic [DW-1:0] wd);
        int n;
        bit got;
        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = AW'(adr); dat_i = wd;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (ack_o) got = 1'b1;
            if (n == 1) begin
                adr_i = ~adr_i;
                dat_i = ~dat_i;
            end
        end
        check(we ? "wr_latency" : "rd_latency", n, WS + 2);
        cyc_i = 1'b0; stb_i = 1'b0;
        if (we) begin
            if (m_hit(adr)) model_mem[m_idx(adr)] = wd;
        end else begin
            last_rd = m_hit(adr) ? model_mem[m_idx(adr)] : '0;
        end
        check(we ? "dat_o_after_wr" : "rd_data", dat_o, last_rd);
        @(posedge clk); #1;
        check("ack_width", ack_o, 0);
    endtask

    // Start a write and drop stb after drop_after edges; no ack may follow.
    task automatic do_abort(input int adr, input logic [DW-1:0] wd, input int drop_after);
        bit seen;
        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = AW'(adr); dat_i = wd;
        seen = 1'b0;
        for (int i = 0; i < drop_after; i++) begin
            @(posedge clk); #1;
            if (ack_o) seen = 1'b1;
        end
        @(negedge clk);
        stb_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ack_o) seen = 1'b1;
        end
        check("abort_no_ack", seen, 0);
        cyc_i = 1'b0;
    endtask

    initial begin
        int n1, n2;
        int adr;
        bit we;
        logic [DW-1:0] wd;

        for (int i = 0; i < DC; i++) model_mem[i] = '0;
        last_rd = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", ack_o, 0);
        check("reset_dat", dat_o, 0);
        @(negedge clk);
        rst = 1'b1;

        // Basic write / read-back, including a misaligned unit address
        do_xfer(1'b1, BASE + 2, 16'h1111);
        do_xfer(1'b0, BASE + 2, 16'h0000);
        check("rd_1111", dat_o, 16'h1111);
        do_xfer(1'b0, BASE + 3, 16'h0000);

        // Boundaries: first and last entries, first address past the array, below base
        do_xfer(1'b1, BASE, 16'hA5A5);
        do_xfer(1'b1, BASE + (DC - 1) * AU, 16'h7E57);
        do_xfer(1'b1, BASE + DC * AU, 16'hDEAD);
        do_xfer(1'b0, BASE + DC * AU, 16'h0000);
        check("miss_rd_zero", dat_o, 16'h0000);
        do_xfer(1'b0, BASE + (DC - 1) * AU, 16'h0000);
        check("last_entry", dat_o, 16'h7E57);
        do_xfer(1'b1, BASE - 1, 16'hBEEF);
        do_xfer(1'b0, BASE - 1, 16'h0000);
        do_xfer(1'b0, BASE, 16'h0000);
        check("first_entry", dat_o, 16'hA5A5);

        // Back-to-back: request held high across the ack
        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = AW'(BASE + 2);
        n1 = 0;
        while (!ack_o && n1 < 40) begin @(posedge clk); #1; n1++; end
        check("b2b_first", n1, WS + 2);
        n2 = 0;
        do begin @(posedge clk); #1; n2++; end while (!ack_o && n2 < 40);
        check("b2b_second", n2, WS + 3);
        cyc_i = 1'b0; stb_i = 1'b0;
        last_rd = model_mem[1];
        check("b2b_data", dat_o, last_rd);
        @(posedge clk); #1;

        // Aborts in S_WAIT and in S_ACK leave the entry unchanged
        do_abort(BASE + 2, 16'h2222, 2);
        do_abort(BASE + 2, 16'h3333, WS + 1);
        do_xfer(1'b0, BASE + 2, 16'h0000);
        check("abort_keeps", dat_o, 16'h1111);

        // Randomized traffic around the decoded window
        for (int t = 0; t < 80; t++) begin
            we  = 1'($urandom_range(1, 0));
            adr = int'($urandom_range(BASE + DC * AU + 3, BASE - 3));
            wd  = DW'($urandom);
            do_xfer(we, adr, wd);
        end

        // Make dat_o non-zero, then reset in the middle of a write
        do_xfer(1'b1, BASE + 4, 16'h4444);
        do_xfer(1'b0, BASE + 4, 16'h0000);
        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = AW'(BASE + 6); dat_i = 16'h5555;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_ack", ack_o, 0);
        check("rst_mid_dat", dat_o, 0);
        cyc_i = 1'b0; stb_i = 1'b0;
        for (int i = 0; i < DC; i++) model_mem[i] = '0;
        last_rd = '0;
        @(negedge clk);
        rst = 1'b1;
        do_xfer(1'b0, BASE + 6, 16'h0000);
        check("rst_lost_write", dat_o, 0);
        do_xfer(1'b0, BASE + 4, 16'h0000);
        check("rst_cleared", dat_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
